// File: rtl/fetch_queue_pkg.sv
// Shared CPU fetch-path definitions: bubble instruction and queue entry layout.
package fetch_queue_pkg;

  // addi x0, x0, 0 -- what decode sees when no fetch entry is valid
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus1;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue handshake bundle: push side, pop side, flush and occupancy.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     flush_i;
  logic                     push_valid_i;
  logic [31:0]              push_instr_i;
  logic [31:0]              push_pc_plus1_i;
  logic                     push_ready_o;
  logic                     pop_valid_o;
  logic                     pop_ready_i;
  logic [31:0]              pop_instr_o;
  logic [31:0]              pop_pc_plus1_o;
  logic [$clog2(DEPTH):0]   count_o;

  // Queue side
  modport slave (
    input  flush_i, push_valid_i, push_instr_i, push_pc_plus1_i, pop_ready_i,
    output push_ready_o, pop_valid_o, pop_instr_o, pop_pc_plus1_o, count_o
  );

  // Pipeline side (fetch drives pushes, decode drives pops)
  modport master (
    output flush_i, push_valid_i, push_instr_i, push_pc_plus1_i, pop_ready_i,
    input  push_ready_o, pop_valid_o, pop_instr_o, pop_pc_plus1_o, count_o
  );
endinterface

// File: rtl/fetch_queue_ram.sv
// Fetch queue storage: register array, synchronous write, asynchronous read, no reset.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  fetch_entry_t               wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output fetch_entry_t               rdata
);

  fetch_entry_t mem [DEPTH];

  // Write accepted entry on the rising edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head entry read combinationally
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO: pointers, occupancy and flow control around fetch_queue_ram.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  fq
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ready, pop_valid, push, pop;
  fetch_entry_t  wr_entry, head;

  // Handshake qualification; DEPTH is a power of two so the count MSB alone means full
  always_comb begin
    push_ready = !count_q[AW] && !fq.flush_i;
    pop_valid  = (count_q != '0) && !fq.flush_i;
    push       = fq.push_valid_i && push_ready;
    pop        = pop_valid && fq.pop_ready_i;
  end

  // Next pointer and occupancy; flush empties the queue without touching storage
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fq.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Pack the offered entry for storage
  always_comb begin
    wr_entry.instr    = fq.push_instr_i;
    wr_entry.pc_plus1 = fq.push_pc_plus1_i;
  end

  fetch_queue_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata(wr_entry),
    .raddr(rd_ptr_q),
    .rdata(head)
  );

  // Drive outputs; an invalid head is presented as a bubble
  always_comb begin
    fq.push_ready_o   = push_ready;
    fq.pop_valid_o    = pop_valid;
    fq.pop_instr_o    = pop_valid ? head.instr    : NOP_INSTR;
    fq.pop_pc_plus1_o = pop_valid ? head.pc_plus1 : '0;
    fq.count_o        = count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) fq_if ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .fq   (fq_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: entries in arrival order
  fetch_entry_t mq [$];

  function automatic logic [CW-1:0] exp_count();
    return CW'(mq.size());
  endfunction

  function automatic logic exp_pop_valid();
    return (mq.size() != 0) && !fq_if.flush_i;
  endfunction

  function automatic logic exp_push_ready();
    return (mq.size() < DEPTH) && !fq_if.flush_i;
  endfunction

  function automatic logic [31:0] exp_instr();
    return exp_pop_valid() ? mq[0].instr : NOP_INSTR;
  endfunction

  function automatic logic [31:0] exp_pc();
    return exp_pop_valid() ? mq[0].pc_plus1 : 32'd0;
  endfunction

  task automatic set_in(input logic fl, input logic pv, input logic [31:0] ins,
                        input logic [31:0] pc, input logic pr);
    fq_if.flush_i         = fl;
    fq_if.push_valid_i    = pv;
    fq_if.push_instr_i    = ins;
    fq_if.push_pc_plus1_i = pc;
    fq_if.pop_ready_i     = pr;
  endtask

  // Advance one rising edge, updating the model from the rules, return at the falling edge
  task automatic clock_edge();
    bit do_push, do_pop, do_clear;
    fetch_entry_t e;
    do_clear = reset || fq_if.flush_i;
    do_push  = fq_if.push_valid_i && (mq.size() < DEPTH) && !do_clear;
    do_pop   = fq_if.pop_ready_i && (mq.size() != 0) && !do_clear;
    e.instr    = fq_if.push_instr_i;
    e.pc_plus1 = fq_if.push_pc_plus1_i;
    @(posedge clk);
    if (do_clear) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mq.delete();
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checks++; if (fq_if.count_o !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", fq_if.count_o); end
    checks++; if (fq_if.pop_valid_o !== 1'b0) begin errors++; $display("FAIL reset_pop_valid got %b exp 0", fq_if.pop_valid_o); end
    checks++; if (fq_if.push_ready_o !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %b exp 1", fq_if.push_ready_o); end
    checks++; if (fq_if.pop_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %h exp 00000013", fq_if.pop_instr_o); end
    checks++; if (fq_if.pop_pc_plus1_o !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", fq_if.pop_pc_plus1_o); end
    reset = 1'b0;
  endtask

  task automatic test_single_push();
    set_in(1'b0, 1'b1, 32'h0050_0093, 32'd1, 1'b0);
    clock_edge();
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    checks++; if (fq_if.pop_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", fq_if.pop_valid_o); end
    checks++; if (fq_if.pop_instr_o !== 32'h0050_0093) begin errors++; $display("FAIL single_instr got %h exp 00500093", fq_if.pop_instr_o); end
    checks++; if (fq_if.pop_pc_plus1_o !== 32'd1) begin errors++; $display("FAIL single_pc got %h exp 1", fq_if.pop_pc_plus1_o); end
    checks++; if (fq_if.count_o !== CW'(1)) begin errors++; $display("FAIL single_count got %0d exp 1", fq_if.count_o); end
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    clock_edge();
    checks++; if (fq_if.count_o !== '0) begin errors++; $display("FAIL single_drain got %0d exp 0", fq_if.count_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 32'hA000_0000 + 32'(i), 32'(i + 1), 1'b0);
      clock_edge();
    end
    set_in(1'b0, 1'b1, 32'hDEAD_BEEF, 32'd99, 1'b0);
    #1;
    checks++; if (fq_if.count_o !== CW'(4)) begin errors++; $display("FAIL fill_count got %0d exp 4", fq_if.count_o); end
    checks++; if (fq_if.push_ready_o !== 1'b0) begin errors++; $display("FAIL fill_push_ready got %b exp 0", fq_if.push_ready_o); end
    clock_edge();
    checks++; if (fq_if.count_o !== CW'(4)) begin errors++; $display("FAIL fill_fifth got %0d exp 4", fq_if.count_o); end
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      checks++; if (fq_if.pop_instr_o !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL fill_order[%0d] got %h exp %h", i, fq_if.pop_instr_o, 32'hA000_0000 + 32'(i)); end
      checks++; if (fq_if.pop_pc_plus1_o !== 32'(i + 1)) begin errors++; $display("FAIL fill_pc[%0d] got %h exp %h", i, fq_if.pop_pc_plus1_o, 32'(i + 1)); end
      clock_edge();
    end
    checks++; if (fq_if.pop_valid_o !== 1'b0) begin errors++; $display("FAIL fill_empty got %b exp 0", fq_if.pop_valid_o); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 32'hB000_0000 + 32'(i), 32'(i), 1'b0);
      clock_edge();
    end
    set_in(1'b0, 1'b1, 32'hFACE_F00D, 32'd7, 1'b1);
    clock_edge();
    checks++; if (fq_if.count_o !== CW'(3)) begin errors++; $display("FAIL full_pp_count got %0d exp 3", fq_if.count_o); end
    for (int i = 1; i < 4; i++) begin
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      checks++; if (fq_if.pop_instr_o !== 32'hB000_0000 + 32'(i)) begin errors++; $display("FAIL full_pp_order[%0d] got %h exp %h", i, fq_if.pop_instr_o, 32'hB000_0000 + 32'(i)); end
      clock_edge();
    end
    checks++; if (fq_if.pop_valid_o !== 1'b0) begin errors++; $display("FAIL full_pp_not_stored got %b exp 0", fq_if.pop_valid_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 1'b1, 32'hC000_0000 + 32'(i), 32'(i), 1'b0);
      clock_edge();
    end
    for (int k = 0; k < 10; k++) begin
      set_in(1'b0, 1'b1, 32'hC000_0002 + 32'(k), 32'(k + 2), 1'b1);
      #1;
      checks++; if (fq_if.pop_instr_o !== 32'hC000_0000 + 32'(k)) begin errors++; $display("FAIL b2b_head[%0d] got %h exp %h", k, fq_if.pop_instr_o, 32'hC000_0000 + 32'(k)); end
      clock_edge();
      checks++; if (fq_if.count_o !== CW'(2)) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 2", k, fq_if.count_o); end
    end
    for (int i = 10; i < 12; i++) begin
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      checks++; if (fq_if.pop_instr_o !== 32'hC000_0000 + 32'(i)) begin errors++; $display("FAIL b2b_tail[%0d] got %h exp %h", i, fq_if.pop_instr_o, 32'hC000_0000 + 32'(i)); end
      clock_edge();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 32'hD000_0000 + 32'(i), 32'(i), 1'b0);
      clock_edge();
    end
    set_in(1'b1, 1'b1, 32'hEEEE_0000, 32'd5, 1'b1);
    #1;
    checks++; if (fq_if.pop_valid_o !== 1'b0) begin errors++; $display("FAIL flush_pop_valid got %b exp 0", fq_if.pop_valid_o); end
    checks++; if (fq_if.push_ready_o !== 1'b0) begin errors++; $display("FAIL flush_push_ready got %b exp 0", fq_if.push_ready_o); end
    checks++; if (fq_if.pop_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL flush_instr got %h exp 00000013", fq_if.pop_instr_o); end
    clock_edge();
    for (int k = 0; k < 3; k++) begin
      checks++; if (fq_if.count_o !== '0) begin errors++; $display("FAIL flush_hold[%0d] got %0d exp 0", k, fq_if.count_o); end
      clock_edge();
    end
    set_in(1'b0, 1'b1, 32'hD100_0000, 32'd3, 1'b0);
    #1;
    checks++; if (fq_if.push_ready_o !== 1'b1) begin errors++; $display("FAIL flush_release got %b exp 1", fq_if.push_ready_o); end
    clock_edge();
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    #1;
    checks++; if (fq_if.pop_instr_o !== 32'hD100_0000) begin errors++; $display("FAIL flush_first got %h exp d1000000", fq_if.pop_instr_o); end
    checks++; if (fq_if.count_o !== CW'(1)) begin errors++; $display("FAIL flush_first_count got %0d exp 1", fq_if.count_o); end
    clock_edge();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 1'b1, 32'hE000_0000 + 32'(i), 32'(i), 1'b0);
      clock_edge();
    end
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #2 reset = 1'b1;
    mq.delete();
    #1;
    checks++; if (fq_if.count_o !== '0) begin errors++; $display("FAIL arst_count got %0d exp 0", fq_if.count_o); end
    checks++; if (fq_if.pop_valid_o !== 1'b0) begin errors++; $display("FAIL arst_pop_valid got %b exp 0", fq_if.pop_valid_o); end
    checks++; if (fq_if.pop_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL arst_instr got %h exp 00000013", fq_if.pop_instr_o); end
    #1 reset = 1'b0;
    set_in(1'b0, 1'b1, 32'hE500_0000, 32'd9, 1'b0);
    clock_edge();
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    #1;
    checks++; if (fq_if.pop_instr_o !== 32'hE500_0000) begin errors++; $display("FAIL arst_first got %h exp e5000000", fq_if.pop_instr_o); end
    checks++; if (fq_if.count_o !== CW'(1)) begin errors++; $display("FAIL arst_first_count got %0d exp 1", fq_if.count_o); end
    clock_edge();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(15) == 0), $urandom_range(1) == 1, $urandom, $urandom,
             $urandom_range(2) == 0);
      #1;
      checks++; if (fq_if.count_o !== exp_count()) begin errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", n, fq_if.count_o, exp_count()); end
      checks++; if (fq_if.pop_valid_o !== exp_pop_valid()) begin errors++; $display("FAIL rand_pop_valid[%0d] got %b exp %b", n, fq_if.pop_valid_o, exp_pop_valid()); end
      checks++; if (fq_if.push_ready_o !== exp_push_ready()) begin errors++; $display("FAIL rand_push_ready[%0d] got %b exp %b", n, fq_if.push_ready_o, exp_push_ready()); end
      checks++; if (fq_if.pop_instr_o !== exp_instr()) begin errors++; $display("FAIL rand_instr[%0d] got %h exp %h", n, fq_if.pop_instr_o, exp_instr()); end
      checks++; if (fq_if.pop_pc_plus1_o !== exp_pc()) begin errors++; $display("FAIL rand_pc[%0d] got %h exp %h", n, fq_if.pop_pc_plus1_o, exp_pc()); end
      clock_edge();
    end
  endtask

  initial begin
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    test_reset();
    test_single_push();
    test_fill();
    test_full_push_pop();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
